// File: rtl/mult_pipe.sv
// Bubble-collapsing pipelined RV32M multiplier.
// K multiplier bits are consumed per stage; results leave from the last stage.
module mult_pipe #(
  parameter int XLEN       = 32,
  parameter int NUM_STAGES = 4,
  parameter int ROBN_W     = 5,
  parameter int PRN_W      = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              squash,
  input  logic              start,
  output logic              start_ready,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   rs2,
  input  logic [1:0]        func,
  input  logic [ROBN_W-1:0] robn,
  input  logic [PRN_W-1:0]  dest_prn,
  input  logic              avail,
  output logic              done,
  output logic [XLEN-1:0]   result,
  output logic [ROBN_W-1:0] output_robn,
  output logic [PRN_W-1:0]  output_dest_prn
);

  localparam int W = 2 * XLEN;
  localparam int N = NUM_STAGES;
  localparam int K = XLEN / NUM_STAGES;

  logic              vld    [N];
  logic [1:0]        fn_q   [N];
  logic [ROBN_W-1:0] rob_q  [N];
  logic [PRN_W-1:0]  prn_q  [N];
  logic [W-1:0]      mc_q   [N];
  logic [W-1:0]      ml_q   [N];
  logic [W-1:0]      pp_q   [N];
  logic [N-1:0]      go;

  logic         a_sgn;
  logic         b_sgn;
  logic [W-1:0] ext_a;
  logic [W-1:0] ext_b;

  // Widen operands: MULHU is fully unsigned, MULHSU has unsigned rs2.
  always_comb begin
    a_sgn = (func != 2'b11);
    b_sgn = ~func[1];
    ext_a = {{XLEN{a_sgn & rs1[XLEN-1]}}, rs1};
    ext_b = {{XLEN{b_sgn & rs2[XLEN-1]}}, rs2};
  end

  // A stage may load when it is empty or its occupant moves on.
  always_comb begin
    logic g;
    g = ~vld[N-1] | avail;
    go = '0;
    go[N-1] = g;
    for (int s = N - 2; s >= 0; s--) begin
      g = ~vld[s] | g;
      go[s] = g;
    end
  end

  for (genvar s = 0; s < N; s++) begin : g_stage
    logic              v_in;
    logic [1:0]        fn_in;
    logic [ROBN_W-1:0] rob_in;
    logic [PRN_W-1:0]  prn_in;
    logic [W-1:0]      mc_in;
    logic [W-1:0]      ml_in;
    logic [W-1:0]      pp_in;
    logic [W-1:0]      mc_nx;
    logic [W-1:0]      ml_nx;
    logic [W-1:0]      pp_nx;

    if (s == 0) begin : g_head
      // Stage 0 is fed straight from the issue port.
      always_comb begin
        v_in   = start;
        fn_in  = func;
        rob_in = robn;
        prn_in = dest_prn;
        mc_in  = ext_a;
        ml_in  = ext_b;
        pp_in  = '0;
      end
    end else begin : g_body
      // Later stages are fed from the stage in front.
      always_comb begin
        v_in   = vld[s-1];
        fn_in  = fn_q[s-1];
        rob_in = rob_q[s-1];
        prn_in = prn_q[s-1];
        mc_in  = mc_q[s-1];
        ml_in  = ml_q[s-1];
        pp_in  = pp_q[s-1];
      end
    end

    // One K-bit partial product step; the last step also folds in
    // the sign extension of the multiplier above bit XLEN-1, which
    // is all ones or all zeros and so equals -mcand<<XLEN or 0.
    always_comb begin
      mc_nx = mc_in << K;
      ml_nx = ml_in >> K;
      pp_nx = pp_in + mc_in * {{(W-K){1'b0}}, ml_in[K-1:0]};
      if (s == N - 1 && ml_in[K]) begin
        pp_nx = pp_nx - mc_nx;
      end
    end

    // Stage register: valid moves with the advance rule, squash kills.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        vld[s]   <= 1'b0;
        fn_q[s]  <= '0;
        rob_q[s] <= '0;
        prn_q[s] <= '0;
        mc_q[s]  <= '0;
        ml_q[s]  <= '0;
        pp_q[s]  <= '0;
      end else begin
        if (squash) begin
          vld[s] <= 1'b0;
        end else if (go[s]) begin
          vld[s] <= v_in;
        end
        if (go[s] && v_in) begin
          fn_q[s]  <= fn_in;
          rob_q[s] <= rob_in;
          prn_q[s] <= prn_in;
          mc_q[s]  <= mc_nx;
          ml_q[s]  <= ml_nx;
          pp_q[s]  <= pp_nx;
        end
      end
    end
  end

  // Present the last stage; MUL takes the low half, the rest the high.
  always_comb begin
    start_ready     = go[0];
    done            = vld[N-1];
    output_robn     = rob_q[N-1];
    output_dest_prn = prn_q[N-1];
    if (fn_q[N-1] == 2'b00) begin
      result = pp_q[N-1][XLEN-1:0];
    end else begin
      result = pp_q[N-1][W-1:XLEN];
    end
  end

endmodule

// File: tb/tb_mult_pipe.sv
// Directed testbench for mult_pipe.
// Each task drives one scenario and checks its own expected values.
module tb_mult_pipe;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        squash = 1'b0;
  logic        start = 1'b0;
  logic        avail = 1'b1;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [1:0]  func = '0;
  logic [4:0]  robn = '0;
  logic [5:0]  dest_prn = '0;
  logic        start_ready;
  logic        done;
  logic [31:0] result;
  logic [4:0]  output_robn;
  logic [5:0]  output_dest_prn;

  int n_cmp = 0;
  int n_bad = 0;

  mult_pipe #(
    .XLEN(32), .NUM_STAGES(4), .ROBN_W(5), .PRN_W(6)
  ) dut (
    .clock(clock),
    .reset(reset),
    .squash(squash),
    .start(start),
    .start_ready(start_ready),
    .rs1(rs1),
    .rs2(rs2),
    .func(func),
    .robn(robn),
    .dest_prn(dest_prn),
    .avail(avail),
    .done(done),
    .result(result),
    .output_robn(output_robn),
    .output_dest_prn(output_dest_prn)
  );

  always #5 clock = ~clock;

  task automatic drive(input logic s, input logic [1:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r, input logic [5:0] p);
    start = s;
    func = f;
    rs1 = a;
    rs2 = b;
    robn = r;
    dest_prn = p;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL reset_done: got %b want 0", done);
    end
    n_cmp++;
    if (start_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: got %b want 1", start_ready);
    end
    n_cmp++;
    if (result !== 32'h0) begin
      n_bad++; $display("FAIL reset_result: got %h want 0", result);
    end
    n_cmp++;
    if (output_robn !== 5'd0) begin
      n_bad++; $display("FAIL reset_robn: got %0d want 0", output_robn);
    end
    n_cmp++;
    if (output_dest_prn !== 6'd0) begin
      n_bad++; $display("FAIL reset_prn: got %0d want 0", output_dest_prn);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clock);
    avail = 1'b1;
    drive(1'b1, 2'b00, 32'd7, 32'd6, 5'd3, 6'd9);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock);
      start = 1'b0;
      if (i != 4) begin
        n_cmp++;
        if (done !== 1'b0) begin
          n_bad++; $display("FAIL single_idle c%0d: got %b want 0", i, done);
        end
      end else begin
        n_cmp++;
        if (done !== 1'b1) begin
          n_bad++; $display("FAIL single_done: got %b want 1", done);
        end
        n_cmp++;
        if (result !== 32'd42) begin
          n_bad++; $display("FAIL single_result: got %0d want 42", result);
        end
        n_cmp++;
        if (output_robn !== 5'd3) begin
          n_bad++; $display("FAIL single_robn: got %0d want 3", output_robn);
        end
        n_cmp++;
        if (output_dest_prn !== 6'd9) begin
          n_bad++; $display("FAIL single_prn: got %0d want 9", output_dest_prn);
        end
      end
    end
  endtask

  task automatic test_signed();
    logic [1:0]  fv [8];
    logic [31:0] av [8];
    logic [31:0] bv [8];
    logic [31:0] ev [8];
    fv[0] = 2'b01; av[0] = 32'hFFFFFFFF; bv[0] = 32'h2; ev[0] = 32'hFFFFFFFF;
    fv[1] = 2'b10; av[1] = 32'hFFFFFFFF; bv[1] = 32'h2; ev[1] = 32'hFFFFFFFF;
    fv[2] = 2'b11; av[2] = 32'hFFFFFFFF; bv[2] = 32'h2; ev[2] = 32'h00000001;
    fv[3] = 2'b00; av[3] = 32'h80000000; bv[3] = 32'h80000000; ev[3] = 32'h0;
    fv[4] = 2'b01; av[4] = 32'h2; bv[4] = 32'hFFFFFFFF; ev[4] = 32'hFFFFFFFF;
    fv[5] = 2'b10; av[5] = 32'h2; bv[5] = 32'hFFFFFFFF; ev[5] = 32'h00000001;
    fv[6] = 2'b01; av[6] = 32'h80000000; bv[6] = 32'h80000000; ev[6] = 32'h40000000;
    fv[7] = 2'b10; av[7] = 32'h80000000; bv[7] = 32'h80000000; ev[7] = 32'hC0000000;
    for (int v = 0; v < 8; v++) begin
      @(negedge clock);
      drive(1'b1, fv[v], av[v], bv[v], 5'(v), 6'(v));
      for (int i = 1; i <= 4; i++) begin
        @(negedge clock);
        start = 1'b0;
      end
      n_cmp++;
      if (done !== 1'b1 || result !== ev[v]) begin
        n_bad++;
        $display("FAIL signed_v%0d: got done=%b res=%h want done=1 res=%h",
                 v, done, result, ev[v]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int i;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clock);
      i = c - 4;
      n_cmp++;
      if (c >= 4 && c <= 11) begin
        if (done !== 1'b1 || result !== 32'(i * (i + 1)) ||
            output_robn !== 5'(i)) begin
          n_bad++;
          $display("FAIL b2b_c%0d: got done=%b res=%0d rob=%0d want 1 %0d %0d",
                   c, done, result, output_robn, i * (i + 1), i);
        end
      end else if (done !== 1'b0) begin
        n_bad++; $display("FAIL b2b_idle_c%0d: got %b want 0", c, done);
      end
      if (c < 8) begin
        drive(1'b1, 2'b00, 32'(c), 32'(c + 1), 5'(c), 6'(c));
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      avail = 1'b0;
      drive(1'b1, 2'b00, 32'(10 + acc), 32'd3, 5'(acc), 6'(acc));
      #1;
      n_cmp++;
      if (start_ready !== (acc < 4)) begin
        n_bad++;
        $display("FAIL bp_ready_k%0d: got %b want %b", k, start_ready, acc < 4);
      end
      n_cmp++;
      if (k >= 4) begin
        if (done !== 1'b1 || result !== 32'd30 || output_robn !== 5'd0) begin
          n_bad++;
          $display("FAIL bp_hold_k%0d: got done=%b res=%0d rob=%0d want 1 30 0",
                   k, done, result, output_robn);
        end
      end else if (done !== 1'b0) begin
        n_bad++; $display("FAIL bp_fill_k%0d: got %b want 0", k, done);
      end
      if (acc < 4) acc++;
    end
    for (int k = 0; k <= 4; k++) begin
      @(negedge clock);
      start = 1'b0;
      avail = 1'b1;
      #1;
      n_cmp++;
      if (k < 4) begin
        if (done !== 1'b1 || result !== 32'((10 + k) * 3) ||
            output_robn !== 5'(k)) begin
          n_bad++;
          $display("FAIL bp_drain_k%0d: got done=%b res=%0d rob=%0d want 1 %0d %0d",
                   k, done, result, output_robn, (10 + k) * 3, k);
        end
      end else if (done !== 1'b0) begin
        n_bad++; $display("FAIL bp_empty: got %b want 0", done);
      end
    end
  endtask

  task automatic test_squash();
    avail = 1'b1;
    for (int k = 0; k <= 15; k++) begin
      @(negedge clock);
      if (k >= 4 && k <= 14) begin
        n_cmp++;
        if (done !== 1'b0) begin
          n_bad++; $display("FAIL squash_idle_k%0d: got %b want 0", k, done);
        end
      end else if (k == 15) begin
        n_cmp++;
        if (done !== 1'b1 || result !== 32'd132 || output_robn !== 5'd7) begin
          n_bad++;
          $display("FAIL squash_after: got done=%b res=%0d rob=%0d want 1 132 7",
                   done, result, output_robn);
        end
      end
      start = 1'b0;
      squash = 1'b0;
      if (k < 3) begin
        drive(1'b1, 2'b00, 32'(k + 1), 32'd5, 5'(k), 6'(k));
      end else if (k == 3) begin
        drive(1'b1, 2'b00, 32'd9, 32'd9, 5'd3, 6'd3);
        squash = 1'b1;
      end else if (k == 11) begin
        drive(1'b1, 2'b00, 32'd12, 32'd11, 5'd7, 6'd7);
      end
    end
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic test_async_reset();
    avail = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clock);
      if (k < 4) begin
        drive(1'b1, 2'b00, 32'(k + 2), 32'd2, 5'(k), 6'(k));
      end else begin
        start = 1'b0;
      end
    end
    #1;
    n_cmp++;
    if (done !== 1'b1 || start_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL ar_full: got done=%b rdy=%b want 1 0", done, start_ready);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (done !== 1'b0 || start_ready !== 1'b1 || result !== 32'h0) begin
      n_bad++;
      $display("FAIL ar_now: got done=%b rdy=%b res=%h want 0 1 0",
               done, start_ready, result);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    avail = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      n_cmp++;
      if (done !== 1'b0) begin
        n_bad++; $display("FAIL ar_after_k%0d: got %b want 0", k, done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_signed();
    test_back_to_back();
    test_backpressure();
    test_squash();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end want end by 200000");
    $fatal(1, "timeout");
  end

endmodule
